// File: rtl/ysyx_220053_pipe_ctrl.sv
// Hazard and pipeline control for the 5-stage core: stage enables/flushes, PC select,
// wrong-path fetch tracking after redirects, and stall/flush performance counters.
module ysyx_220053_pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_if_busy,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic             i_ex_valid,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_wen,
  input  logic             i_ex_MemToReg,
  input  logic             i_ex_busy,
  input  logic             i_ex_redirect,
  input  logic             i_m_busy,
  input  logic             i_trap,
  output logic             o_pc_en,
  output logic [1:0]       o_pc_sel,
  output logic             o_id_en,
  output logic             o_ex_en,
  output logic             o_m_en,
  output logic             o_wb_en,
  output logic             o_id_flush,
  output logic             o_ex_flush,
  output logic             o_m_flush,
  output logic             o_wb_flush,
  output logic             o_redir_pend,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic {RUN = 1'b0, REDIR = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_load_use;
  logic             w_act_redir;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_load_use = i_ex_valid & i_ex_MemToReg & i_ex_wen & (i_ex_rd != 5'd0) & i_id_valid &
                      ((i_id_rs1_used & (i_id_rs1 == i_ex_rd)) |
                       (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));

  always_comb begin
    o_pc_en      = 1'b1;
    o_pc_sel     = 2'b00;
    o_id_en      = 1'b1;
    o_ex_en      = 1'b1;
    o_m_en       = 1'b1;
    o_wb_en      = 1'b1;
    o_id_flush   = 1'b0;
    o_ex_flush   = 1'b0;
    o_m_flush    = 1'b0;
    o_wb_flush   = 1'b0;
    o_redir_pend = 1'b0;
    w_act_redir  = 1'b0;
    w_next       = r_state;
    if (!rst_n) begin
      o_pc_en    = 1'b0;
      o_id_en    = 1'b0;
      o_ex_en    = 1'b0;
      o_m_en     = 1'b0;
      o_wb_en    = 1'b0;
      o_id_flush = 1'b1;
      o_ex_flush = 1'b1;
      o_m_flush  = 1'b1;
      o_wb_flush = 1'b1;
      w_next     = RUN;
    end else if (r_state == RUN) begin
      if (i_trap) begin
        o_pc_sel    = 2'b10;
        o_id_flush  = 1'b1;
        o_ex_flush  = 1'b1;
        o_m_flush   = 1'b1;
        o_wb_flush  = 1'b1;
        w_act_redir = 1'b1;
      end else if (i_m_busy) begin
        o_pc_en    = 1'b0;
        o_id_en    = 1'b0;
        o_ex_en    = 1'b0;
        o_m_en     = 1'b0;
        o_wb_flush = 1'b1;
      end else if (i_ex_busy) begin
        o_pc_en   = 1'b0;
        o_id_en   = 1'b0;
        o_ex_en   = 1'b0;
        o_m_flush = 1'b1;
      end else if (i_ex_redirect) begin
        o_pc_sel    = 2'b01;
        o_id_flush  = 1'b1;
        o_ex_flush  = 1'b1;
        w_act_redir = 1'b1;
      end else if (w_load_use) begin
        o_pc_en    = 1'b0;
        o_id_en    = 1'b0;
        o_ex_flush = 1'b1;
      end else if (i_if_busy) begin
        o_pc_en    = 1'b0;
        o_id_flush = 1'b1;
      end
      // A redirect issued while a fetch is outstanding makes that fetch wrong-path.
      if (w_act_redir && i_if_busy) w_next = REDIR;
    end else begin
      o_redir_pend = 1'b1;
      o_pc_en      = 1'b0;
      o_id_flush   = 1'b1;
      if (i_trap) begin
        o_pc_en     = 1'b1;
        o_pc_sel    = 2'b10;
        o_ex_flush  = 1'b1;
        o_m_flush   = 1'b1;
        o_wb_flush  = 1'b1;
        w_act_redir = 1'b1;
      end else if (i_m_busy) begin
        o_id_en    = 1'b0;
        o_ex_en    = 1'b0;
        o_m_en     = 1'b0;
        o_wb_flush = 1'b1;
      end else if (i_ex_busy) begin
        o_id_en   = 1'b0;
        o_ex_en   = 1'b0;
        o_m_flush = 1'b1;
      end
      // The wrong-path instruction arrives this cycle and is dropped by id_flush.
      if (!i_if_busy) w_next = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (!o_pc_en)    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_act_redir) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_ysyx_220053_pipe_ctrl.sv
// Directed table-driven bench for ysyx_220053_pipe_ctrl plus multi-cycle sequences.
module tb_ysyx_220053_pipe_ctrl;

  typedef struct {
    logic       trap, m_busy, ex_busy, ex_redirect, if_busy;
    logic       ex_valid, ex_mtr, ex_wen;
    logic [4:0] ex_rd;
    logic       id_valid;
    logic [4:0] rs1;
    logic       rs1_used;
    logic [4:0] rs2;
    logic       rs2_used;
  } vin_t;

  typedef struct {
    vin_t        in;
    logic [10:0] exp;
    logic        evt;
  } vec_t;

  // {pc_en, pc_sel[1:0], id_en, ex_en, m_en, wb_en, id_flush, ex_flush, m_flush, wb_flush}
  localparam logic [10:0] E_DEF   = 11'b1_00_1111_0000;
  localparam logic [10:0] E_LU    = 11'b0_00_0111_0100;
  localparam logic [10:0] E_REDIR = 11'b1_01_1111_1100;
  localparam logic [10:0] E_EXB   = 11'b0_00_0011_0010;
  localparam logic [10:0] E_MB    = 11'b0_00_0001_0001;
  localparam logic [10:0] E_TRAP  = 11'b1_10_1111_1111;
  localparam logic [10:0] E_IFB   = 11'b0_00_1111_1000;
  localparam logic [10:0] E_RST   = 11'b0_00_0000_1111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic if_busy, id_valid, rs1_used, rs2_used, ex_valid, ex_wen, ex_mtr;
  logic ex_busy, ex_redirect, m_busy, trap;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic pc_en, id_en, ex_en, m_en, wb_en, id_flush, ex_flush, m_flush, wb_flush, redir_pend;
  logic [1:0] pc_sel;
  logic [31:0] stall_cnt, flush_cnt;
  logic p4_pc_en, p4_id_en, p4_ex_en, p4_m_en, p4_wb_en;
  logic p4_id_flush, p4_ex_flush, p4_m_flush, p4_wb_flush, p4_redir_pend;
  logic [1:0] p4_pc_sel;
  logic [3:0] p4_stall_cnt, p4_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[15];
  logic [31:0] m_stall, m_flush_evt, s0, f0;

  always #5 clk = ~clk;

  ysyx_220053_pipe_ctrl #(.CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_if_busy(if_busy), .i_id_valid(id_valid),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_wen(ex_wen), .i_ex_MemToReg(ex_mtr),
    .i_ex_busy(ex_busy), .i_ex_redirect(ex_redirect), .i_m_busy(m_busy), .i_trap(trap),
    .o_pc_en(pc_en), .o_pc_sel(pc_sel), .o_id_en(id_en), .o_ex_en(ex_en), .o_m_en(m_en),
    .o_wb_en(wb_en), .o_id_flush(id_flush), .o_ex_flush(ex_flush), .o_m_flush(m_flush),
    .o_wb_flush(wb_flush), .o_redir_pend(redir_pend), .o_stall_cnt(stall_cnt),
    .o_flush_cnt(flush_cnt)
  );

  ysyx_220053_pipe_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_if_busy(if_busy), .i_id_valid(id_valid),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_wen(ex_wen), .i_ex_MemToReg(ex_mtr),
    .i_ex_busy(ex_busy), .i_ex_redirect(ex_redirect), .i_m_busy(m_busy), .i_trap(trap),
    .o_pc_en(p4_pc_en), .o_pc_sel(p4_pc_sel), .o_id_en(p4_id_en), .o_ex_en(p4_ex_en),
    .o_m_en(p4_m_en), .o_wb_en(p4_wb_en), .o_id_flush(p4_id_flush), .o_ex_flush(p4_ex_flush),
    .o_m_flush(p4_m_flush), .o_wb_flush(p4_wb_flush), .o_redir_pend(p4_redir_pend),
    .o_stall_cnt(p4_stall_cnt), .o_flush_cnt(p4_flush_cnt)
  );

  function automatic vin_t mk(input int tr, mb, eb, er, ib, ev, mtr, wen, rd,
                              idv, r1, u1, r2, u2);
    vin_t v;
    v.trap = tr[0]; v.m_busy = mb[0]; v.ex_busy = eb[0]; v.ex_redirect = er[0];
    v.if_busy = ib[0]; v.ex_valid = ev[0]; v.ex_mtr = mtr[0]; v.ex_wen = wen[0];
    v.ex_rd = rd[4:0]; v.id_valid = idv[0]; v.rs1 = r1[4:0]; v.rs1_used = u1[0];
    v.rs2 = r2[4:0]; v.rs2_used = u2[0];
    return v;
  endfunction

  task automatic drive(input vin_t v);
    trap = v.trap; m_busy = v.m_busy; ex_busy = v.ex_busy; ex_redirect = v.ex_redirect;
    if_busy = v.if_busy; ex_valid = v.ex_valid; ex_mtr = v.ex_mtr; ex_wen = v.ex_wen;
    ex_rd = v.ex_rd; id_valid = v.id_valid; id_rs1 = v.rs1; rs1_used = v.rs1_used;
    id_rs2 = v.rs2; rs2_used = v.rs2_used;
  endtask

  task automatic chk_out(input string name, input logic [10:0] exp, input logic exp_pend);
    logic [10:0] act;
    act = {pc_en, pc_sel, id_en, ex_en, m_en, wb_en, id_flush, ex_flush, m_flush, wb_flush};
    n_checks++;
    if (act !== exp || redir_pend !== exp_pend) begin
      n_errors++;
      $display("FAIL %s: outputs=%b pend=%b, expected outputs=%b pend=%b",
               name, act, redir_pend, exp, exp_pend);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0));
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  initial begin
    tbl[0]  = '{mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0), E_DEF,   1'b0};
    tbl[1]  = '{mk(0,0,0,0,0, 1,1,1,5, 1,5,1,1,1), E_LU,    1'b0};
    tbl[2]  = '{mk(0,0,0,0,0, 1,1,1,0, 1,0,1,1,1), E_DEF,   1'b0};
    tbl[3]  = '{mk(0,0,0,0,0, 1,1,1,5, 1,5,0,1,1), E_DEF,   1'b0};
    tbl[4]  = '{mk(0,0,0,0,0, 1,1,1,5, 1,2,1,5,1), E_LU,    1'b0};
    tbl[5]  = '{mk(0,0,0,0,0, 1,1,0,5, 1,5,1,1,1), E_DEF,   1'b0};
    tbl[6]  = '{mk(0,0,0,1,0, 0,0,0,0, 0,0,0,0,0), E_REDIR, 1'b1};
    tbl[7]  = '{mk(0,0,1,1,0, 0,0,0,0, 0,0,0,0,0), E_EXB,   1'b0};
    tbl[8]  = '{mk(0,1,0,0,0, 0,0,0,0, 0,0,0,0,0), E_MB,    1'b0};
    tbl[9]  = '{mk(1,1,0,1,0, 0,0,0,0, 0,0,0,0,0), E_TRAP,  1'b1};
    tbl[10] = '{mk(0,0,0,0,1, 0,0,0,0, 0,0,0,0,0), E_IFB,   1'b0};
    tbl[11] = '{mk(0,0,0,1,0, 1,1,1,5, 1,5,1,1,1), E_REDIR, 1'b1};
    tbl[12] = '{mk(0,0,0,0,1, 1,1,1,5, 1,5,1,1,1), E_LU,    1'b0};
    tbl[13] = '{mk(0,0,0,0,0, 1,1,1,5, 0,5,1,1,1), E_DEF,   1'b0};
    tbl[14] = '{mk(0,0,0,0,0, 0,1,1,5, 1,5,1,1,1), E_DEF,   1'b0};

    drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0));
    #12;
    chk_out("reset_outputs", E_RST, 1'b0);
    chk_val("reset_stall_cnt", stall_cnt, 0);
    chk_val("reset_flush_cnt", flush_cnt, 0);
    #10 rst_n = 1'b1;
    step();

    m_stall = 0;
    m_flush_evt = 0;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].in);
      @(negedge clk);
      chk_out($sformatf("vec%0d", i), tbl[i].exp, 1'b0);
      if (!tbl[i].exp[10]) m_stall++;
      if (tbl[i].evt) m_flush_evt++;
      step();
    end
    chk_val("table_stall_cnt", stall_cnt, m_stall);
    chk_val("table_flush_cnt", flush_cnt, m_flush_evt);

    // Load-use bubble followed by the bubble in EX
    s0 = stall_cnt;
    drive(mk(0,0,0,0,0, 1,1,1,5, 1,6,0,5,1));
    @(negedge clk) chk_out("lu_cycle1", E_LU, 1'b0);
    step();
    drive(mk(0,0,0,0,0, 0,1,1,5, 1,6,0,5,1));
    @(negedge clk) chk_out("lu_cycle2", E_DEF, 1'b0);
    step();
    chk_val("lu_stall_delta", stall_cnt - s0, 1);

    // Redirect with a fetch outstanding for three cycles
    s0 = stall_cnt; f0 = flush_cnt;
    drive(mk(0,0,0,1,1, 0,0,0,0, 0,0,0,0,0));
    @(negedge clk) chk_out("redir_c0", E_REDIR, 1'b0);
    step();
    drive(mk(0,0,0,0,1, 0,0,0,0, 0,0,0,0,0));
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk) chk_out($sformatf("redir_c%0d", c), E_IFB, 1'b1);
      step();
    end
    drive(mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0));
    @(negedge clk) chk_out("redir_c3", E_IFB, 1'b1);
    step();
    @(negedge clk) chk_out("redir_back_run", E_DEF, 1'b0);
    chk_val("redir_flush_delta", flush_cnt - f0, 1);
    chk_val("redir_stall_delta", stall_cnt - s0, 3);
    step();

    // Priority: trap with m_busy and ex_redirect
    f0 = flush_cnt;
    drive(mk(1,1,0,1,0, 0,0,0,0, 0,0,0,0,0));
    @(negedge clk) chk_out("prio_trap", E_TRAP, 1'b0);
    step();
    chk_val("prio_flush_delta", flush_cnt - f0, 1);

    // m_busy held four cycles
    s0 = stall_cnt;
    drive(mk(0,1,0,0,0, 0,0,0,0, 0,0,0,0,0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk) chk_out($sformatf("mbusy_c%0d", c), E_MB, 1'b0);
      step();
    end
    chk_val("mbusy_stall_delta", stall_cnt - s0, 4);

    // Trap taken while a wrong-path fetch is pending stays in REDIR
    drive(mk(0,0,0,1,1, 0,0,0,0, 0,0,0,0,0));
    step();
    drive(mk(1,0,0,0,1, 0,0,0,0, 0,0,0,0,0));
    @(negedge clk) chk_out("redir_trap", E_TRAP, 1'b1);
    step();
    drive(mk(0,0,0,0,1, 0,0,0,0, 0,0,0,0,0));
    @(negedge clk) chk_out("redir_after_trap", E_IFB, 1'b1);

    // Asynchronous reset while in REDIR
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_reset_outputs", E_RST, 1'b0);
    chk_val("async_reset_stall", stall_cnt, 0);
    chk_val("async_reset_flush", flush_cnt, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk_out("post_reset_run", E_IFB, 1'b0);
    step();
    chk_out("post_reset_no_redir", E_IFB, 1'b0);
    chk_val("post_reset_stall", stall_cnt, 1);

    // 4-bit counter wrap after 17 stall cycles
    do_reset();
    drive(mk(0,0,0,0,1, 0,0,0,0, 0,0,0,0,0));
    for (int c = 0; c < 17; c++) step();
    chk_val("wrap_cnt4", {28'd0, p4_stall_cnt}, 1);
    chk_val("wrap_cnt32", stall_cnt, 17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_220053_pipe_ctrl.md
# ysyx_220053_pipe_ctrl

Central hazard and pipeline control unit for the 5-stage core (IF/ID/EX/M/WB). It drives the `enable` and `flush` inputs of the ID, EX, M and WB pipeline registers, plus the PC update, from these inputs:
- stage hazard status;
- branch redirects;
- traps;
- multi-cycle unit busy signals.

It also tracks wrong-path fetches that are still in flight after a redirect, and keeps stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_busy  in  1  IFU waiting on instruction memory; no instruction is delivered this cycle
- id_valid  in  1  ID register holds a valid instruction
- id_rs1 / id_rs2  in  5 each  source register indices in ID
- id_rs1_used / id_rs2_used  in  1 each  source is actually read
- ex_valid  in  1  EX register holds a valid instruction
- ex_rd  in  5  destination register in EX
- ex_wen  in  1  EX instruction writes the register file
- ex_MemToReg  in  1  EX instruction is a load
- ex_busy  in  1  multi-cycle mul/div in progress in EX
- ex_redirect  in  1  taken branch or jump resolved in EX
- m_busy  in  1  LSU waiting on data memory
- trap  in  1  WB-stage trap or mret; redirect to CSR target
- pc_en  out  1  PC register update enable
- pc_sel  out  2  00 sequential, 01 branch target, 10 trap target
- id_en, ex_en, m_en, wb_en  out  1 each  pipeline register enables
- id_flush, ex_flush, m_flush, wb_flush  out  1 each  pipeline register flushes (bubble insert)
- redir_pend  out  1  state is REDIR
- stall_cnt  out  CNT_W  cycles with pc_en=0 while out of reset
- flush_cnt  out  CNT_W  redirect events (trap or ex_redirect acted on)

## Operation
Defaults: all *_en=1, all *_flush=0, pc_en=1, pc_sel=00.

The first matching hazard below wins, and its overrides apply on top of the defaults.

1. **trap**
   - pc_en=1, pc_sel=10.
   - id_flush = ex_flush = m_flush = wb_flush = 1.
   - The LSU aborts on m_flush.
2. **m_busy**
   - pc_en = id_en = ex_en = m_en = 0.
   - wb_flush=1.
3. **ex_busy**
   - pc_en = id_en = ex_en = 0.
   - m_flush=1.
4. **ex_redirect**
   - pc_en=1, pc_sel=01.
   - id_flush = ex_flush = 1.
5. **load-use**, i.e. ex_valid & ex_MemToReg & ex_wen & ex_rd≠0 & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd))
   - pc_en = id_en = 0.
   - ex_flush=1.
6. **if_busy**
   - pc_en=0.
   - id_flush=1.

Flushes override enables in the register; the controller may assert both.

State machine: RUN, REDIR.
- **RUN to REDIR**: a trap or ex_redirect acted on while if_busy=1. The fetch in flight is wrong-path.
- **In REDIR**:
  - id_flush is forced to 1.
  - pc_en is forced to 0, except on a new trap, which is still taken (pc_en=1, sel=10) and stays in REDIR.
  - Rows 2–3 above still apply to the downstream enables and flushes.
- **REDIR exit**: the cycle if_busy=0. The returned instruction is dropped (id_flush=1, pc_en=0) and the next state is RUN.
  - The IFU fetches the target from PC in the next cycle.

Counters:
- stall_cnt +1 every cycle pc_en=0.
- flush_cnt +1 on each cycle a trap or ex_redirect is acted on; ex_redirect masked by rows 1–3 does not count.
- Both wrap modulo 2^CNT_W.

## Timing
- All control outputs are combinational from the inputs and the state. The pipeline registers sample them at the next posedge clk.
- State and counters are updated at posedge clk.
- Reset (rst_n=0, asynchronous):
  - state=RUN, stall_cnt=0, flush_cnt=0.
  - Outputs forced: pc_en=0, all *_en=0, all *_flush=1, pc_sel=00, redir_pend=0.
  - Counters do not count during reset.
- Reset deasserted mid-stall: the first cycle evaluates from RUN, and no pending redirect survives.
- Load-use bubble: exactly 1 cycle, provided EX has no further hazard.
- Simultaneous trap + ex_redirect: trap wins, and flush_cnt increments by 1 only.
- ex_redirect while ex_busy: held off. It is acted on in the first cycle ex_busy=0, since EX is frozen.

## Test plan
- **Load-use**: ex = lw x5, ID = add x6,x5,x1 (both valid), no other hazards.
  - Cycle 1: pc_en=0, id_en=0, ex_flush=1.
  - Next cycle (EX now holds the bubble, ex_valid=0): all defaults.
  - stall_cnt=1.
- **x0 / unused source**: ex_rd=0, or the matching rs has its _used=0.
  - No stall.
- **Redirect with fetch in flight**: ex_redirect=1 and if_busy=1 for 3 cycles.
  - Cycle 0: pc_sel=01, pc_en=1, id_flush=ex_flush=1, then redir_pend=1.
  - Cycles 1–2: id_flush=1, pc_en=0.
  - Cycle 3 (if_busy=0): id_flush=1, pc_en=0.
  - Then RUN.
  - flush_cnt=1, stall_cnt=3.
- **Priority**: trap + m_busy + ex_redirect in the same cycle.
  - pc_sel=10, all four flushes=1, flush_cnt +1.
- **m_busy for 4 cycles**:
  - pc_en = id_en = ex_en = m_en = 0 and wb_flush=1 on each cycle.
  - stall_cnt +4.
- **Reset**: assert rst_n=0 asynchronously during REDIR.
  - Immediately: redir_pend=0, all flushes=1, counters=0.
- **Counter wrap**: with CNT_W=4, 17 stall cycles.
  - stall_cnt=1.
